led_pattern_gen: RTL

Parametrised successor to the board LED chaser. Drives NUM_LEDS LEDs from a programmable prescaler. Supports four run-time patterns: chase, bounce, blink and fill bar. It sits at the top of the FPGA design as a heartbeat and status indicator next to the VexiiRiscv/AES core, with mode, enable and divider taken from a config register or from switches.

---
 rtl/led_pkg.sv | 16 +
 rtl/led_prescaler.sv | 35 +++
 rtl/led_pattern_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared pattern-mode and bounce-direction encodings for the LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: pulses step every div+1 enabled cycles; clr restarts the count.
module led_prescaler #(
  parameter int PRESC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               step
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // Lowering div below cnt is not special-cased: cnt wraps through 2^PRESC_W.
  assign step = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = step ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED heartbeat/status pattern generator: chase, bounce, blink and fill-bar patterns.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 7,
  parameter int PRESC_W  = 24,
  parameter int POS_W    = (NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PRESC_W-1:0]  div,
  output logic [NUM_LEDS-1:0] led,
  output logic [POS_W-1:0]    pos,
  output logic                tick
);

  localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LED_ALL  = '1;
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);

  mode_e               mode_q, mode_d, mode_in;
  dir_e                dir_q, dir_d;
  logic [POS_W-1:0]    pos_q, pos_d, pos_wrap, bnc_pos;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                tick_q, tick_d;
  logic                restart, step;

  assign mode_in  = mode_e'(mode);
  assign restart  = (mode_in != mode_q);
  assign pos_wrap = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);

  // Restart clears the prescaler so the new pattern begins a full period later.
  led_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (restart),
    .div (div),
    .step(step)
  );

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    led_d   = led_q;
    tick_d  = 1'b0;
    bnc_pos = pos_q;
    if (restart) begin
      mode_d = mode_in;
      dir_d  = DIR_UP;
      pos_d  = '0;
      led_d  = (mode_in == MODE_BLINK) ? LED_ALL : LED_ONE;
    end else if (step) begin
      tick_d = 1'b1;
      unique case (mode_q)
        MODE_CHASE: begin
          pos_d = pos_wrap;
          led_d = LED_ONE << pos_wrap;
        end
        MODE_BOUNCE: begin
          // Direction flips on arrival at an end so end LEDs show for one step.
          if (NUM_LEDS > 1) begin
            if (dir_q == DIR_UP) begin
              bnc_pos = pos_q + POS_W'(1);
              dir_d   = (bnc_pos == POS_LAST) ? DIR_DOWN : DIR_UP;
            end else begin
              bnc_pos = pos_q - POS_W'(1);
              dir_d   = (bnc_pos == '0) ? DIR_UP : DIR_DOWN;
            end
          end
          pos_d = bnc_pos;
          led_d = LED_ONE << bnc_pos;
        end
        MODE_BLINK: begin
          pos_d = '0;
          led_d = ~led_q;
        end
        MODE_FILL: begin
          pos_d = pos_wrap;
          led_d = LED_ALL >> (POS_LAST - pos_wrap);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_CHASE;
      dir_q  <= DIR_UP;
      pos_q  <= '0;
      led_q  <= LED_ONE;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign tick = tick_q;

endmodule
